inst_fetch: RTL and testbench
=============================

INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, meaning the PC value loaded on reset.
REQ-002 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 Port imem_req  output  1  instruction memory read request.
REQ-005 Port imem_addr  output  32  instruction memory byte address, equal to PC.
REQ-006 Port imem_ack  input  1  memory has valid data on imem_rdata this cycle.
REQ-007 Port imem_rdata  input  32  instruction word from memory.
REQ-008 Port Inst_code  output  32  instruction presented to the decoder (OP+rs+rt+rd+shamt+func).
REQ-009 Port inst_valid  output  1  Inst_code is valid.
REQ-010 Port inst_ready  input  1  decoder/execute accepts Inst_code this cycle.
REQ-011 Port PC_s  input  2  next-PC select: 00 sequential, 01 branch, 10 register jump (jr), 11 absolute jump.
REQ-012 Port Z  input  1  branch condition; the branch is taken when PC_s=01 and Z=1.
REQ-013 Port imm_offset  input  16  branch word offset, signed.
REQ-014 Port address  input  26  jump word address.
REQ-015 Port rs_data  input  32  jr target byte address.
REQ-016 Port PC  output  32  address of the instruction currently held in Inst_code or being fetched.
REQ-017 Port inst_count  output  32  count of accepted instructions.
REQ-018 Port addr_err  output  1  sticky flag for a misaligned jr target.

Function
REQ-019 The FSM SHALL have two states, FETCH and ISSUE.
REQ-020 In FETCH: imem_req=1, imem_addr=PC held stable, inst_valid=0.
REQ-021 In FETCH with imem_ack=1 at a clock edge, the block SHALL latch Inst_code<=imem_rdata and move to ISSUE.
REQ-022 In FETCH with imem_ack=0, the block SHALL stay in FETCH with no limit on wait cycles.
REQ-023 In ISSUE: imem_req=0, inst_valid=1, Inst_code and PC held constant until accepted.
REQ-024 An accept SHALL be inst_valid=1 and inst_ready=1 at a clock edge; on accept the block SHALL load the next PC, increment inst_count, and return to FETCH.
REQ-025 PC_s, Z, imm_offset, address and rs_data SHALL be sampled only in the accept cycle and ignored at all other times.
REQ-026 PC4 SHALL be PC+4, modulo 2^32; 32'hFFFF_FFFC wraps to 32'h0000_0000.
REQ-027 With PC_s=00, or PC_s=01 and Z=0, the next PC SHALL be PC4.
REQ-028 With PC_s=01 and Z=1, the next PC SHALL be PC4 + (sign-extended imm_offset << 2), modulo 2^32.
REQ-029 With PC_s=11, the next PC SHALL be {PC4[31:28], address, 2'b00}.
REQ-030 With PC_s=10, the next PC SHALL be {rs_data[31:2], 2'b00}; if rs_data[1:0]!=0, addr_err SHALL be set and stay set until reset.
REQ-031 Throughput SHALL be at best one instruction per 2 cycles: ack in the first FETCH cycle, valid the next cycle, accept in that cycle.
REQ-032 inst_ready while in FETCH SHALL have no effect.
REQ-033 inst_count SHALL wrap from 32'hFFFF_FFFF to 0.

Reset
REQ-034 On rst_n=0, immediately and regardless of clk, the block SHALL set: state=FETCH, PC=RESET_PC, Inst_code=0, inst_valid=0, inst_count=0, addr_err=0.
REQ-035 While rst_n=0, imem_req SHALL be forced to 0.
REQ-036 After rst_n deasserts, the first rising edge SHALL begin a fetch from RESET_PC.
REQ-037 Reset mid-handshake (FETCH waiting for ack, or ISSUE waiting for ready) SHALL abandon the transaction with no accept counted.

Verification
REQ-038 Sequential: memory acks every request with zero wait, inst_ready=1, PC_s=00 -> imem_addr sequence 0,4,8,C; inst_valid every 2nd cycle; inst_count=4 after 4 accepts.
REQ-039 Branch: PC=0x100, PC_s=01, Z=1, imm_offset=16'hFFFE -> next PC=0xFC; same inputs with Z=0 -> next PC=0x104.
REQ-040 Jump and jr: PC=0x3000_0010, PC_s=11, address=26'h0000040 -> next PC=0x3000_0100; PC_s=10, rs_data=0x0000_2002 -> next PC=0x2000 and addr_err=1.
REQ-041 Backpressure and wait: ack delayed 3 cycles, then inst_ready held 0 for 5 cycles with PC_s toggling -> Inst_code and PC stable, imem_req=0 throughout ISSUE, only the PC_s value in the accept cycle applied.
REQ-042 Wrap: PC=0xFFFF_FFFC, PC_s=00 -> next PC=0; inst_count preloaded via 2^32-1 accepts (or forced) -> 0.
REQ-043 Async reset: rst_n pulsed low between clock edges during ISSUE -> inst_valid, PC and inst_count clear without waiting for a clock edge, and the fetch restarts at RESET_PC.

Source files
------------

// File: rtl/inst_fetch_if.sv
// Instruction memory read port between the fetch unit and instruction memory.
interface inst_fetch_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_ack,
      input  imem_rdata
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_ack,
      output imem_rdata
   );
endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch unit: fetches one word at PC, holds it for the decoder
// until accepted, then steps PC (sequential, branch, jr or absolute jump).
//
// state | meaning
// FETCH | request outstanding at PC, waiting for imem_ack
// ISSUE | Inst_code valid, waiting for inst_ready
module inst_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic         clk,
   input  logic         rst_n,
   inst_fetch_if.master imem,
   output logic [31:0]  Inst_code,
   output logic         inst_valid,
   input  logic         inst_ready,
   input  logic [1:0]   PC_s,
   input  logic         Z,
   input  logic [15:0]  imm_offset,
   input  logic [25:0]  address,
   input  logic [31:0]  rs_data,
   output logic [31:0]  PC,
   output logic [31:0]  inst_count,
   output logic         addr_err
);

   typedef enum logic {
      FETCH = 1'b0,
      ISSUE = 1'b1
   } state_t;

   state_t      state_q;
   state_t      state_d;
   logic        accept;
   logic        fetch_done;
   logic [31:0] pc4;
   logic [31:0] br_off;
   logic [31:0] pc_next;
   logic        jr_misaligned;

   assign imem.imem_addr = PC;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= FETCH;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state and handshake outputs; imem_req is gated by rst_n so it
   // drops the instant reset is asserted
   always_comb begin
      state_d       = state_q;
      imem.imem_req = 1'b0;
      inst_valid    = 1'b0;
      accept        = 1'b0;
      fetch_done    = 1'b0;
      case (state_q)
         FETCH: begin
            imem.imem_req = rst_n;
            if (imem.imem_ack) begin
               fetch_done = 1'b1;
               state_d    = ISSUE;
            end
         end
         ISSUE: begin
            inst_valid = 1'b1;
            if (inst_ready) begin
               accept  = 1'b1;
               state_d = FETCH;
            end
         end
         default: state_d = FETCH;
      endcase
   end

   // Next-PC selection; only consumed in the accept cycle
   always_comb begin
      pc4           = PC + 32'd4;
      br_off        = {{14{imm_offset[15]}}, imm_offset, 2'b00};
      jr_misaligned = (PC_s == 2'b10) && (rs_data[1:0] != 2'b00);
      pc_next       = pc4;
      case (PC_s)
         2'b00:   pc_next = pc4;
         2'b01:   pc_next = Z ? (pc4 + br_off) : pc4;
         2'b10:   pc_next = {rs_data[31:2], 2'b00};
         2'b11:   pc_next = {pc4[31:28], address, 2'b00};
         default: pc_next = pc4;
      endcase
   end

   // Instruction latch, PC, accepted-instruction counter and sticky jr error
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         Inst_code  <= 32'h0000_0000;
         PC         <= RESET_PC;
         inst_count <= 32'h0000_0000;
         addr_err   <= 1'b0;
      end else begin
         if (fetch_done) begin
            Inst_code <= imem.imem_rdata;
         end
         if (accept) begin
            PC         <= pc_next;
            inst_count <= inst_count + 32'd1;
            if (jr_misaligned) begin
               addr_err <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed self-checking bench for inst_fetch.
module tb_inst_fetch;

   logic        clk;
   logic        rst_n;
   logic [31:0] Inst_code;
   logic        inst_valid;
   logic        inst_ready;
   logic [1:0]  PC_s;
   logic        Z;
   logic [15:0] imm_offset;
   logic [25:0] address;
   logic [31:0] rs_data;
   logic [31:0] PC;
   logic [31:0] inst_count;
   logic        addr_err;

   int n_checks = 0;
   int n_pass   = 0;
   logic [31:0] exp_count = 32'd0;

   inst_fetch_if imem ();

   inst_fetch #(.RESET_PC(32'h0000_0000)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .imem       (imem.master),
      .Inst_code  (Inst_code),
      .inst_valid (inst_valid),
      .inst_ready (inst_ready),
      .PC_s       (PC_s),
      .Z          (Z),
      .imm_offset (imm_offset),
      .address    (address),
      .rs_data    (rs_data),
      .PC         (PC),
      .inst_count (inst_count),
      .addr_err   (addr_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Starting at a negedge in FETCH: ack immediately with word, end at a
   // negedge in ISSUE.
   task automatic fetch_word(input logic [31:0] word);
      imem.imem_ack   = 1'b1;
      imem.imem_rdata = word;
      @(posedge clk);
      @(negedge clk);
      imem.imem_ack   = 1'b0;
      imem.imem_rdata = 32'hDEAD_BEEF;
   endtask

   // Starting at a negedge in ISSUE: accept with the given next-PC inputs,
   // end at a negedge in FETCH.
   task automatic accept_with(input logic [1:0] pcs, input logic z,
                              input logic [15:0] imm, input logic [25:0] adr,
                              input logic [31:0] rs);
      PC_s       = pcs;
      Z          = z;
      imm_offset = imm;
      address    = adr;
      rs_data    = rs;
      inst_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      inst_ready = 1'b0;
      PC_s       = 2'b00;
      Z          = 1'b0;
      exp_count  = exp_count + 32'd1;
   endtask

   // Redirect PC via an aligned jr
   task automatic goto_pc(input logic [31:0] target);
      fetch_word(32'h0000_0008);
      accept_with(2'b10, 1'b0, 16'h0, 26'h0, target);
   endtask

   task automatic test_reset;
      rst_n           = 1'b0;
      inst_ready      = 1'b0;
      PC_s            = 2'b00;
      Z               = 1'b0;
      imm_offset      = 16'h0;
      address         = 26'h0;
      rs_data         = 32'h0;
      imem.imem_ack   = 1'b0;
      imem.imem_rdata = 32'h0;
      repeat (2) @(negedge clk);
      n_checks++; if (imem.imem_req !== 1'b0) $display("FAIL reset_req got=%0b exp=0", imem.imem_req); else n_pass++;
      n_checks++; if (PC !== 32'h0) $display("FAIL reset_pc got=%h exp=0", PC); else n_pass++;
      n_checks++; if (inst_valid !== 1'b0 || Inst_code !== 32'h0) $display("FAIL reset_inst valid=%0b code=%h exp 0/0", inst_valid, Inst_code); else n_pass++;
      n_checks++; if (inst_count !== 32'h0 || addr_err !== 1'b0) $display("FAIL reset_cnt cnt=%h err=%0b exp 0/0", inst_count, addr_err); else n_pass++;
      rst_n = 1'b1;
      @(negedge clk);
      n_checks++; if (imem.imem_req !== 1'b1 || imem.imem_addr !== 32'h0) $display("FAIL reset_first_fetch req=%0b addr=%h exp 1/0", imem.imem_req, imem.imem_addr); else n_pass++;
   endtask

   task automatic test_sequential;
      for (int i = 0; i < 4; i++) begin
         n_checks++; if (imem.imem_addr !== 32'(i * 4) || imem.imem_req !== 1'b1 || inst_valid !== 1'b0) $display("FAIL seq_fetch%0d addr=%h req=%0b valid=%0b exp %h/1/0", i, imem.imem_addr, imem.imem_req, inst_valid, 32'(i * 4)); else n_pass++;
         fetch_word(32'hA000_0000 + 32'(i));
         n_checks++; if (inst_valid !== 1'b1 || Inst_code !== 32'hA000_0000 + 32'(i) || imem.imem_req !== 1'b0) $display("FAIL seq_issue%0d valid=%0b code=%h req=%0b exp 1/%h/0", i, inst_valid, Inst_code, imem.imem_req, 32'hA000_0000 + 32'(i)); else n_pass++;
         accept_with(2'b00, 1'b0, 16'h0, 26'h0, 32'h0);
      end
      n_checks++; if (inst_count !== 32'd4) $display("FAIL seq_count got=%0d exp=4", inst_count); else n_pass++;
      n_checks++; if (PC !== 32'h10) $display("FAIL seq_pc got=%h exp=10", PC); else n_pass++;
   endtask

   task automatic test_branch;
      goto_pc(32'h0000_0100);
      n_checks++; if (PC !== 32'h100) $display("FAIL br_setup got=%h exp=100", PC); else n_pass++;
      fetch_word(32'h1000_FFFE);
      accept_with(2'b01, 1'b1, 16'hFFFE, 26'h3FF_FFFF, 32'hFFFF_FFFF);
      n_checks++; if (PC !== 32'h0000_00FC) $display("FAIL br_taken got=%h exp=000000fc", PC); else n_pass++;
      goto_pc(32'h0000_0100);
      fetch_word(32'h1000_FFFE);
      accept_with(2'b01, 1'b0, 16'hFFFE, 26'h0, 32'h0);
      n_checks++; if (PC !== 32'h0000_0104) $display("FAIL br_not_taken got=%h exp=00000104", PC); else n_pass++;
   endtask

   task automatic test_jump;
      goto_pc(32'h3000_0010);
      n_checks++; if (addr_err !== 1'b0) $display("FAIL jr_aligned_err got=%0b exp=0", addr_err); else n_pass++;
      fetch_word(32'h0800_0040);
      accept_with(2'b11, 1'b1, 16'h7FFF, 26'h000_0040, 32'h0000_0003);
      n_checks++; if (PC !== 32'h3000_0100) $display("FAIL jump_abs got=%h exp=30000100", PC); else n_pass++;
      n_checks++; if (addr_err !== 1'b0) $display("FAIL jump_no_err got=%0b exp=0", addr_err); else n_pass++;
      fetch_word(32'h0000_0008);
      accept_with(2'b10, 1'b0, 16'h0, 26'h0, 32'h0000_2002);
      n_checks++; if (PC !== 32'h0000_2000) $display("FAIL jr_pc got=%h exp=00002000", PC); else n_pass++;
      n_checks++; if (addr_err !== 1'b1) $display("FAIL jr_err got=%0b exp=1", addr_err); else n_pass++;
      fetch_word(32'h0);
      accept_with(2'b00, 1'b0, 16'h0, 26'h0, 32'h0);
      n_checks++; if (addr_err !== 1'b1 || PC !== 32'h0000_2004) $display("FAIL jr_err_sticky err=%0b pc=%h exp 1/00002004", addr_err, PC); else n_pass++;
   endtask

   task automatic test_backpressure;
      logic [31:0] cnt_before;
      cnt_before = inst_count;
      inst_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         n_checks++; if (imem.imem_req !== 1'b1 || imem.imem_addr !== 32'h2004 || inst_valid !== 1'b0) $display("FAIL wait%0d req=%0b addr=%h valid=%0b exp 1/00002004/0", i, imem.imem_req, imem.imem_addr, inst_valid); else n_pass++;
         @(negedge clk);
      end
      inst_ready = 1'b0;
      n_checks++; if (inst_count !== cnt_before) $display("FAIL ready_in_fetch cnt=%h exp=%h", inst_count, cnt_before); else n_pass++;
      fetch_word(32'hCAFE_0001);
      for (int i = 0; i < 5; i++) begin
         PC_s    = 2'(i + 1);
         Z       = 1'b1;
         rs_data = 32'h0000_0F03;
         address = 26'h155_5555;
         n_checks++; if (Inst_code !== 32'hCAFE_0001 || PC !== 32'h2004 || imem.imem_req !== 1'b0 || inst_valid !== 1'b1) $display("FAIL hold%0d code=%h pc=%h req=%0b valid=%0b exp cafe0001/00002004/0/1", i, Inst_code, PC, imem.imem_req, inst_valid); else n_pass++;
         @(negedge clk);
      end
      accept_with(2'b00, 1'b1, 16'hFFF0, 26'h155_5555, 32'h0000_0F03);
      n_checks++; if (PC !== 32'h0000_2008 || inst_count !== exp_count) $display("FAIL bp_accept pc=%h cnt=%h exp 00002008/%h", PC, inst_count, exp_count); else n_pass++;
   endtask

   task automatic test_wrap;
      goto_pc(32'hFFFF_FFFC);
      fetch_word(32'h0);
      accept_with(2'b00, 1'b0, 16'h0, 26'h0, 32'h0);
      n_checks++; if (PC !== 32'h0) $display("FAIL pc_wrap got=%h exp=0", PC); else n_pass++;
      force dut.inst_count = 32'hFFFF_FFFF;
      #1;
      release dut.inst_count;
      @(negedge clk);
      fetch_word(32'h0);
      accept_with(2'b00, 1'b0, 16'h0, 26'h0, 32'h0);
      n_checks++; if (inst_count !== 32'h0) $display("FAIL count_wrap got=%h exp=0", inst_count); else n_pass++;
   endtask

   task automatic test_async_reset;
      fetch_word(32'h5555_AAAA);
      #2;
      rst_n = 1'b0;
      #1;
      n_checks++; if (inst_valid !== 1'b0 || PC !== 32'h0 || inst_count !== 32'h0) $display("FAIL async_clear valid=%0b pc=%h cnt=%h exp 0/0/0", inst_valid, PC, inst_count); else n_pass++;
      n_checks++; if (imem.imem_req !== 1'b0 || Inst_code !== 32'h0) $display("FAIL async_req req=%0b code=%h exp 0/0", imem.imem_req, Inst_code); else n_pass++;
      #1;
      rst_n = 1'b1;
      exp_count = 32'd0;
      @(negedge clk);
      n_checks++; if (imem.imem_req !== 1'b1 || imem.imem_addr !== 32'h0 || inst_valid !== 1'b0) $display("FAIL async_restart req=%0b addr=%h valid=%0b exp 1/0/0", imem.imem_req, imem.imem_addr, inst_valid); else n_pass++;
      fetch_word(32'h0000_1234);
      accept_with(2'b00, 1'b0, 16'h0, 26'h0, 32'h0);
      n_checks++; if (inst_count !== 32'd1 || PC !== 32'h4) $display("FAIL async_after cnt=%h pc=%h exp 1/4", inst_count, PC); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_sequential();
      test_branch();
      test_jump();
      test_backpressure();
      test_wrap();
      test_async_reset();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout reached at %0t", $time);
      $fatal(1, "timeout");
   end

endmodule
